dpram_port_arbiter: RTL and testbench

Two-requester arbiter for port A of the 1024x16 dual-port board RAM. It lets the button-driven board sequencer and a second agent (display reader or CPU) share one RAM port, using round-robin grants, an optional bounded lock for read-modify-write pairs, and per-requester read-valid tagging. It sits between the requesters and the RAM's addr_a/din_a/wen_a/dout_a pins. Port B is not touched.

---
 rtl/dpram_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/dpram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// ============================================================================
// dpram_pkg: shared types and constants for the dual-port board RAM blocks.
// Rev 1.0
// ============================================================================
`default_nettype none

package dpram_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2: combinational two-way round-robin picker (onehot grant).
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
// ============================================================================
// dpram_port_arbiter: round-robin sharing of RAM port A between two requesters,
// with a bounded lock for RMW pairs when DPRAM_ARB_LOCK_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic              wen0,
  input  logic              wen1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] din_a,
  output logic              wen_a,
  input  logic [DATA_W-1:0] dout_a
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_last;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic [1:0] w_pick;
  logic [1:0] w_gnt;

  rr_pick2 u_pick (
    .req         ({req1, req0}),
    .last_served (r_last),
    .gnt         (w_pick)
  );

  // An owner keeps the port only while it keeps requesting; reset blocks all grants.
  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      if (r_state == ARB_OWN0 && req0)      w_gnt = 2'b01;
      else if (r_state == ARB_OWN1 && req1) w_gnt = 2'b10;
      else                                  w_gnt = w_pick;
    end
  end

  assign gnt0   = w_gnt[REQ0];
  assign gnt1   = w_gnt[REQ1];
  assign addr_a = w_gnt[REQ1] ? addr1 : addr0;
  assign din_a  = w_gnt[REQ1] ? din1  : din0;
  assign wen_a  = (w_gnt[REQ0] & wen0) | (w_gnt[REQ1] & wen1);

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = dout_a;
  assign rdata1  = dout_a;

`ifdef DPRAM_ARB_LOCK_EN
  localparam int unsigned          c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w:0]     c_lock_lim = (c_cnt_w + 1)'(LOCK_MAX);

  logic [c_cnt_w-1:0] r_lock_cnt;
  logic [c_cnt_w-1:0] w_lock_cnt_nxt;
  logic [c_cnt_w:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_lock_cnt} + {{c_cnt_w{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt    = ARB_IDLE;
    w_lock_cnt_nxt = '0;
    if (w_cnt_inc < c_lock_lim) begin
      if (w_gnt[REQ0] && lock0) begin
        w_state_nxt    = ARB_OWN0;
        w_lock_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
      end else if (w_gnt[REQ1] && lock1) begin
        w_state_nxt    = ARB_OWN1;
        w_lock_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_lock_cnt <= '0;
    else       r_lock_cnt <= w_lock_cnt_nxt;
  end
`else
  localparam int unsigned c_lock_max_unused = LOCK_MAX;
  logic w_lock_unused;

  assign w_lock_unused = lock0 ^ lock1;
  assign w_state_nxt   = ARB_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_last    <= 1'(REQ1);
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt[REQ0])      r_last <= 1'(REQ0);
      else if (w_gnt[REQ1]) r_last <= 1'(REQ1);
      r_rvalid0 <= w_gnt[REQ0] & ~wen0;
      r_rvalid1 <= w_gnt[REQ1] & ~wen1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
// ============================================================================
// tb_dpram_port_arbiter: directed + randomized bench with a behavioural model
// of the arbiter rules and a harness RAM on port A.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dpram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LOCK_MAX = 4;
`ifdef DPRAM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, wen0, wen1;
  logic [AW-1:0] addr0, addr1, addr_a;
  logic [DW-1:0] din0, din1, din_a, dout_a, rdata0, rdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, wen_a;

  dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .wen0(wen0), .wen1(wen1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .addr_a(addr_a), .din_a(din_a), .wen_a(wen_a), .dout_a(dout_a)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 2) return 16'd9;
    if (i == 5) return 16'd7;
    return 16'(i * 37 + 11);
  endfunction

  // Harness RAM: read-before-write, one-cycle read latency.
  logic [DW-1:0] ram [1024];
  logic          ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (wen_a) begin
      ram[addr_a] <= din_a;
    end
    dout_a <= ram[addr_a];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner (-1 none), consecutive locked grants, last winner.
  int            m_owner, m_cnt, m_g;
  bit            m_last, m_rv0, m_rv1;
  logic [DW-1:0] m_mem [1024];
  logic [DW-1:0] m_dout;

  function automatic int model_grant();
    if (reset) return -1;
    if (m_owner == 0 && req0) return 0;
    if (m_owner == 1 && req1) return 1;
    if (req0 && req1) return m_last ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic settle();
    logic w;
    #3;
    m_g = model_grant();
    w = (m_g == 0) ? wen0 : (m_g == 1) ? wen1 : 1'b0;
    check("gnt0", 32'(gnt0), 32'(m_g == 0));
    check("gnt1", 32'(gnt1), 32'(m_g == 1));
    check("wen_a", 32'(wen_a), 32'(w));
    if (m_g >= 0) check("addr_a", 32'(addr_a), 32'((m_g == 1) ? addr1 : addr0));
    if (m_g >= 0 && w) check("din_a", 32'(din_a), 32'((m_g == 1) ? din1 : din0));
    check("rvalid0", 32'(rvalid0), 32'(m_rv0));
    check("rvalid1", 32'(rvalid1), 32'(m_rv1));
    if (m_rv0) check("rdata0", 32'(rdata0), 32'(m_dout));
    if (m_rv1) check("rdata1", 32'(rdata1), 32'(m_dout));
  endtask

  task automatic tick();
    logic [AW-1:0] a;
    logic          w, lk;
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0;
    end else begin
      m_rv0 = (m_g == 0) && !wen0;
      m_rv1 = (m_g == 1) && !wen1;
      if (m_g >= 0) begin
        a  = (m_g == 1) ? addr1 : addr0;
        w  = (m_g == 1) ? wen1  : wen0;
        lk = (m_g == 1) ? lock1 : lock0;
        m_dout = m_mem[a];
        if (w) m_mem[a] = (m_g == 1) ? din1 : din0;
        m_last = (m_g == 1);
        if (LOCK_EN && lk && (m_cnt + 1 < LOCK_MAX)) begin
          m_owner = m_g; m_cnt = m_cnt + 1;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  logic [DW-1:0] cap;
  bit            p0, p1;

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = init_val(i);
    m_owner = -1; m_cnt = 0; m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_dout = '0; m_g = -1;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    wen0 = 1'b1; wen1 = 1'b0; addr0 = 10'd5; addr1 = '0; din0 = 16'hDEAD; din1 = '0;

    // Reset gates grants and writes.
    settle();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_wen_a", 32'(wen_a), 32'd0);
    tick();
    cyc();
    reset = 1'b0; req0 = 1'b0; wen0 = 1'b0;
    settle();
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    tick();

    // Single read of RAM[5].
    req0 = 1'b1; addr0 = 10'd5;
    settle();
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_addr_a", 32'(addr_a), 32'd5);
    check("rd_wen_a", 32'(wen_a), 32'd0);
    tick();
    req0 = 1'b0;
    settle();
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_rdata0", 32'(rdata0), 32'h0007);
    check("rd_rvalid1", 32'(rvalid1), 32'd0);
    tick();

    // Requester 1 alone, then both held: 0,1,0,1.
    req1 = 1'b1; addr1 = 10'd20;
    cyc();
    req0 = 1'b1; addr0 = 10'd10;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("alt_gnt0", 32'(gnt0), 32'(k % 2 == 0));
      check("alt_gnt1", 32'(gnt1), 32'(k % 2 == 1));
      tick();
    end

    // RMW on addr 2 with requester 1 continuously requesting.
    addr1 = 10'd30; addr0 = 10'd2; wen0 = 1'b0; lock0 = 1'b1;
    settle();
    check("rmw_rd_gnt0", 32'(gnt0), 32'd1);
    tick();
    cap = rdata0 + 16'd1;
    wen0 = 1'b1; din0 = cap; lock0 = 1'b0;
    settle();
    check("rmw_rvalid0", 32'(rvalid0), 32'd1);
    check("rmw_rdata0", 32'(rdata0), 32'd9);
    check("rmw_wr_gnt0", 32'(gnt0), 32'(LOCK_EN));
    check("rmw_wr_gnt1", 32'(gnt1), 32'(!LOCK_EN));
    tick();
    req0 = !LOCK_EN;
    settle();
    check("rmw_next_gnt1", 32'(gnt1), 32'(LOCK_EN));
    tick();
    req0 = 1'b0; wen0 = 1'b0;
    cyc();
    check("rmw_ram2", 32'(ram[2]), 32'd10);

    // Lock cap: req1 only to make requester 0 the favourite, then 6 locked cycles.
    cyc();
    req0 = 1'b1; lock0 = 1'b1; addr0 = 10'd50;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("cap_gnt0", 32'(gnt0), LOCK_EN ? 32'(k < 4 || k == 5) : 32'(k % 2 == 0));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    cyc();

    // Reset asserted in the write cycle of a locked RMW.
    req0 = 1'b1; lock0 = 1'b1; addr0 = 10'd40;
    cyc();
    reset = 1'b1; wen0 = 1'b1; din0 = 16'hBEEF; lock0 = 1'b0;
    settle();
    check("rstrmw_wen_a", 32'(wen_a), 32'd0);
    check("rstrmw_gnt0", 32'(gnt0), 32'd0);
    tick();
    reset = 1'b0; req0 = 1'b0; wen0 = 1'b0;
    settle();
    check("rstrmw_rvalid0", 32'(rvalid0), 32'd0);
    tick();
    check("rstrmw_ram40", 32'(ram[40]), 32'(init_val(40)));

    // Random traffic; each requester holds its request until granted.
    p0 = 1'b0; p1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; addr0 = 10'($urandom_range(0, 15)); wen0 = 1'($urandom_range(0, 2) == 0);
        din0 = 16'($urandom); lock0 = 1'($urandom_range(0, 2) != 0);
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; addr1 = 10'($urandom_range(0, 15)); wen1 = 1'($urandom_range(0, 2) == 0);
        din1 = 16'($urandom); lock1 = 1'($urandom_range(0, 2) != 0);
      end
      req0 = p0; req1 = p1;
      reset = ($urandom_range(0, 79) == 0);
      cyc();
      if (m_g == 0) p0 = 1'b0;
      if (m_g == 1) p1 = 1'b0;
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) check("final_ram", 32'(ram[i]), 32'(m_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
